// File: rtl/mpu_bus_initiator.sv
// Host-side command port to ChronoCube MPU bus master.
// Runs one bus cycle per command with parameterised setup, strobe and hold phases.
module mpu_bus_initiator #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [1:0]            cmd_be,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_was_read,

    output logic                  _mpu_en,
    output logic                  _mpu_rd,
    output logic                  _mpu_wr,
    output logic [1:0]            _mpu_be,
    output logic [ADDR_WIDTH-1:0] mpu_addr,
    output logic [DATA_WIDTH-1:0] mpu_wdata,
    input  logic [DATA_WIDTH-1:0] mpu_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
        $error("mpu_bus_initiator: SETUP_CYCLES must be 1..15");
    end
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("mpu_bus_initiator: STROBE_CYCLES must be 1..15");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("mpu_bus_initiator: HOLD_CYCLES must be 1..15");
    end

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  en_n_q, en_n_d;
    logic                  rd_n_q, rd_n_d;
    logic                  wr_n_q, wr_n_d;
    logic [1:0]            be_n_q, be_n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_was_read_q, rsp_was_read_d;
    logic                  phase_done;

    assign phase_done = (cnt_q == 4'd0);
    assign cmd_ready  = (state_q == ST_IDLE) & ~reset;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        write_d        = write_q;
        en_n_d         = en_n_q;
        rd_n_d         = rd_n_q;
        wr_n_d         = wr_n_q;
        be_n_d         = be_n_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_was_read_d = rsp_was_read_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    write_d = cmd_write;
                    en_n_d  = 1'b0;
                    be_n_d  = ~cmd_be;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_write ? cmd_wdata : '0;
                end
            end
            ST_SETUP: begin
                if (phase_done) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                    rd_n_d  = write_q;
                    wr_n_d  = ~write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (phase_done) begin
                    // The edge closing the last strobe cycle captures read data.
                    state_d        = ST_HOLD;
                    cnt_d          = HOLD_LOAD;
                    rd_n_d         = 1'b1;
                    wr_n_d         = 1'b1;
                    rsp_valid_d    = 1'b1;
                    rsp_rdata_d    = write_q ? '0 : mpu_rdata;
                    rsp_was_read_d = ~write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (phase_done) begin
                    state_d = ST_IDLE;
                    en_n_d  = 1'b1;
                    be_n_d  = 2'b11;
                    addr_d  = '0;
                    wdata_d = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 4'd0;
            write_q        <= 1'b0;
            en_n_q         <= 1'b1;
            rd_n_q         <= 1'b1;
            wr_n_q         <= 1'b1;
            be_n_q         <= 2'b11;
            addr_q         <= '0;
            wdata_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_was_read_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            write_q        <= write_d;
            en_n_q         <= en_n_d;
            rd_n_q         <= rd_n_d;
            wr_n_q         <= wr_n_d;
            be_n_q         <= be_n_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_was_read_q <= rsp_was_read_d;
        end
    end

    assign _mpu_en      = en_n_q;
    assign _mpu_rd      = rd_n_q;
    assign _mpu_wr      = wr_n_q;
    assign _mpu_be      = be_n_q;
    assign mpu_addr     = addr_q;
    assign mpu_wdata    = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_was_read = rsp_was_read_q;

endmodule
